// File: rtl/sec_tick_gen.sv
// Seconds source for the stopwatch: 1 Hz square wave, 1-cycle tick and 0..59 count with run/pause/clear.
// Define DEBOUNCE_EN to build the per-button debounce filter; otherwise the synchronised level is used.
module sec_tick_gen #(
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_run,
  input  logic       btn_clr,
  output logic       sec,
  output logic       sec_tick,
  output logic [5:0] r_second,
  output logic       running
);

  localparam int unsigned       PrescW    = $clog2(CLK_HZ);
  localparam logic [PrescW-1:0] PrescLast = PrescW'(CLK_HZ - 1);
  localparam logic [PrescW-1:0] PrescHalf = PrescW'(CLK_HZ / 2 - 1);

  typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

  if (CLK_HZ < 4 || (CLK_HZ % 2) != 0 || DEBOUNCE_CYCLES == 0) begin : g_param_err
    $error("sec_tick_gen: CLK_HZ must be even and >= 4, DEBOUNCE_CYCLES must be >= 1");
  end

  logic r_run_s1, r_run_s2, r_clr_s1, r_clr_s2;
  logic w_run_flt, w_clr_flt;
  logic r_run_prev, r_clr_prev, r_run_p, r_clr_p;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_run_s1 <= 1'b0;
      r_run_s2 <= 1'b0;
      r_clr_s1 <= 1'b0;
      r_clr_s2 <= 1'b0;
    end else begin
      r_run_s1 <= btn_run;
      r_run_s2 <= r_run_s1;
      r_clr_s1 <= btn_clr;
      r_clr_s2 <= r_clr_s1;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int unsigned    DbW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);

  logic [DbW-1:0] r_run_cnt, r_clr_cnt;
  logic           r_run_flt, r_clr_flt;

  // A level is accepted only after disagreeing with the filter for DEBOUNCE_CYCLES straight cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_run_cnt <= '0;
      r_clr_cnt <= '0;
      r_run_flt <= 1'b0;
      r_clr_flt <= 1'b0;
    end else begin
      if (r_run_s2 == r_run_flt) begin
        r_run_cnt <= '0;
      end else if (r_run_cnt == DbLast) begin
        r_run_flt <= r_run_s2;
        r_run_cnt <= '0;
      end else begin
        r_run_cnt <= r_run_cnt + DbW'(1);
      end
      if (r_clr_s2 == r_clr_flt) begin
        r_clr_cnt <= '0;
      end else if (r_clr_cnt == DbLast) begin
        r_clr_flt <= r_clr_s2;
        r_clr_cnt <= '0;
      end else begin
        r_clr_cnt <= r_clr_cnt + DbW'(1);
      end
    end
  end

  assign w_run_flt = r_run_flt;
  assign w_clr_flt = r_clr_flt;
`else
  assign w_run_flt = r_run_s2;
  assign w_clr_flt = r_clr_s2;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_run_prev <= 1'b0;
      r_clr_prev <= 1'b0;
      r_run_p    <= 1'b0;
      r_clr_p    <= 1'b0;
    end else begin
      r_run_prev <= w_run_flt;
      r_clr_prev <= w_clr_flt;
      r_run_p    <= w_run_flt & ~r_run_prev;
      r_clr_p    <= w_clr_flt & ~r_clr_prev;
    end
  end

  state_e r_state, w_state_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (r_clr_p) begin
      w_state_next = StIdle;
    end else if (r_run_p) begin
      case (r_state)
        StIdle:  w_state_next = StRun;
        StRun:   w_state_next = StPause;
        StPause: w_state_next = StRun;
        default: w_state_next = StIdle;
      endcase
    end
  end

  logic [PrescW-1:0] r_presc, w_presc_next;
  logic              r_sec, w_sec_next;
  logic              r_tick, w_tick_next;
  logic [5:0]        w_second_next;
  logic              r_running, w_running_next;
  logic              w_advance;

  // The prescaler only moves in cycles that start and stay in RUN, so a pause freezes it exactly.
  always_comb begin
    w_advance      = (r_state == StRun) && (w_state_next == StRun);
    w_presc_next   = r_presc;
    w_sec_next     = r_sec;
    w_tick_next    = 1'b0;
    w_second_next  = r_second;
    w_running_next = (w_state_next == StRun);
    if (r_clr_p) begin
      w_presc_next  = '0;
      w_sec_next    = 1'b0;
      w_second_next = '0;
    end else if (w_advance) begin
      if (r_presc == PrescLast) begin
        w_presc_next  = '0;
        w_tick_next   = 1'b1;
        w_sec_next    = 1'b1;
        w_second_next = (r_second == 6'd59) ? 6'd0 : r_second + 6'd1;
      end else begin
        w_presc_next = r_presc + PrescW'(1);
        if (r_presc == PrescHalf) begin
          w_sec_next = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc   <= '0;
      r_sec     <= 1'b0;
      r_tick    <= 1'b0;
      r_second  <= '0;
      r_running <= 1'b0;
    end else begin
      r_presc   <= w_presc_next;
      r_sec     <= w_sec_next;
      r_tick    <= w_tick_next;
      r_second  <= w_second_next;
      r_running <= w_running_next;
    end
  end

  assign sec      = r_sec;
  assign sec_tick = r_tick;
  assign running  = r_running;

endmodule

// File: tb/tb_sec_tick_gen.sv
// Self-checking bench for sec_tick_gen (CLK_HZ=10, DEBOUNCE_CYCLES=4); expected ticks go through a queue.
// Honours DEBOUNCE_EN the same way the design does.
module tb_sec_tick_gen;

  localparam int unsigned ClkHz    = 10;
  localparam int unsigned DbCycles = 4;
`ifdef DEBOUNCE_EN
  localparam int unsigned Lat  = DbCycles + 3;
  localparam bit          DbOn = 1'b1;
`else
  localparam int unsigned Lat  = 3;
  localparam bit          DbOn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_run = 1'b0;
  logic       btn_clr = 1'b0;
  logic       sec, sec_tick, running;
  logic [5:0] r_second;

  typedef struct {
    int unsigned at;
    logic [5:0]  secs;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;

  sec_tick_gen #(
    .CLK_HZ         (ClkHz),
    .DEBOUNCE_CYCLES(DbCycles)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_run (btn_run),
    .btn_clr (btn_clr),
    .sec     (sec),
    .sec_tick(sec_tick),
    .r_second(r_second),
    .running (running)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n   = 1'b0;
    btn_run = 1'b0;
    btn_clr = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    sb.delete();
  endtask

  task automatic wait_running(input logic level, input int bound, output int n, output bit ok,
                              output int unsigned tick_at);
    n       = 0;
    ok      = 1'b0;
    tick_at = 0;
    while (n < bound && !ok) begin
      step();
      n++;
      if (sec_tick === 1'b1) tick_at = cyc;
      if (running === level) ok = 1'b1;
    end
  endtask

  task automatic wait_tick(input int bound, output int unsigned at, output bit ok);
    int n = 0;
    ok = 1'b0;
    at = 0;
    while (n < bound && !ok) begin
      step();
      n++;
      if (sec_tick === 1'b1) begin
        ok = 1'b1;
        at = cyc;
      end
    end
  endtask

  task automatic press_run(output int unsigned run_at, output bit ok);
    int          n;
    int unsigned tk;
    btn_run = 1'b1;
    wait_running(1'b1, Lat + 10, n, ok, tk);
    run_at  = cyc;
    btn_run = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if ({sec, sec_tick, r_second, running} !== 9'b0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got sec=%b tick=%b second=%0d running=%b want all 0",
                 cyc, sec, sec_tick, r_second, running);
      end
    end
  endtask

  task automatic test_start();
    int unsigned k, run_at, at, tk;
    int          n;
    bit          ok;
    exp_t        e;
    apply_reset();
    step();
    btn_run = 1'b1;
    k = cyc;
    step();  // first edge that samples btn_run
    wait_running(1'b1, 40, n, ok, tk);
    run_at = cyc;
    checks++;
    if (!ok || n != int'(Lat)) begin
      errors++;
      $display("FAIL start_latency got %0d cycles (seen=%0b) want %0d", n, ok, Lat);
    end
    e.at = run_at + ClkHz;
    e.secs = 6'd1;
    sb.push_back(e);
    while (cyc < k + 10) step();
    btn_run = 1'b0;
    wait_tick(3 * ClkHz, at, ok);
    checks++;
    if (!ok || sb.size() == 0) begin
      errors++;
      $display("FAIL first_tick got none want tick at cyc %0d", e.at);
    end else begin
      e = sb.pop_front();
      if (at !== e.at || r_second !== e.secs || sec !== 1'b1) begin
        errors++;
        $display("FAIL first_tick got cyc=%0d second=%0d sec=%b want cyc=%0d second=%0d sec=1",
                 at, r_second, sec, e.at, e.secs);
      end
    end
    step();
    checks++;
    if (sec_tick !== 1'b0) begin
      errors++;
      $display("FAIL tick_width got sec_tick=%b want 0", sec_tick);
    end
    repeat (3) step();
    checks++;
    if (sec !== 1'b1) begin
      errors++;
      $display("FAIL sec_high got sec=%b at tick+4 want 1", sec);
    end
    step();
    checks++;
    if (sec !== 1'b0) begin
      errors++;
      $display("FAIL sec_fall got sec=%b at tick+5 want 0", sec);
    end
  endtask

  task automatic test_minute();
    int unsigned run_at, at;
    bit          ok;
    exp_t        e;
    apply_reset();
    step();
    press_run(run_at, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL minute_start got running=%b want 1", running);
    end
    for (int i = 1; i <= 60; i++) begin
      e.at = run_at + ClkHz * i;
      e.secs = 6'(i % 60);
      sb.push_back(e);
    end
    for (int i = 0; i < 60; i++) begin
      wait_tick(ClkHz + 2, at, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || at !== e.at || r_second !== e.secs) begin
        errors++;
        $display("FAIL minute_tick%0d got seen=%0b cyc=%0d second=%0d want cyc=%0d second=%0d",
                 i + 1, ok, at, r_second, e.at, e.secs);
        break;
      end
    end
  endtask

  task automatic test_pause();
    int unsigned r, t0, s, at, f, tk, tick_at;
    int          n, bad;
    bit          ok;
    exp_t        e;
    apply_reset();
    step();
    press_run(r, ok);
    wait_tick(ClkHz + 2, t0, ok);
    checks++;
    if (!ok || t0 !== r + ClkHz || r_second !== 6'd1) begin
      errors++;
      $display("FAIL pause_first_tick got cyc=%0d second=%0d want cyc=%0d second=1",
               t0, r_second, r + ClkHz);
    end
    e.at = t0 + ClkHz;
    e.secs = 6'd2;
    sb.push_back(e);
    // Press so the pause lands with the prescaler frozen at 6.
    tick_at = 0;
    repeat (16 - Lat) begin
      step();
      if (sec_tick === 1'b1) tick_at = cyc;
    end
    btn_run = 1'b1;
    wait_running(1'b0, Lat + 10, n, ok, tk);
    if (tk != 0) tick_at = tk;
    f = cyc;
    btn_run = 1'b0;
    checks++;
    if (!ok || f !== t0 + 17) begin
      errors++;
      $display("FAIL pause_entry got running fall at cyc %0d want %0d", f, t0 + 17);
    end
    e = sb.pop_front();
    checks++;
    if (tick_at !== e.at || r_second !== e.secs) begin
      errors++;
      $display("FAIL pause_pre_tick got cyc=%0d second=%0d want cyc=%0d second=%0d",
               tick_at, r_second, e.at, e.secs);
    end
    bad = 0;
    repeat (50) begin
      step();
      if (sec_tick !== 1'b0 || r_second !== 6'd2 || sec !== 1'b0 || running !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL pause_hold got %0d disturbed cycles want 0", bad);
    end
    press_run(s, ok);
    e.at = s + 4;
    e.secs = 6'd3;
    sb.push_back(e);
    wait_tick(ClkHz + 2, at, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || at !== e.at || r_second !== e.secs) begin
      errors++;
      $display("FAIL pause_resume got seen=%0b cyc=%0d second=%0d want cyc=%0d second=%0d",
               ok, at, r_second, e.at, e.secs);
    end
  endtask

  task automatic test_clear();
    int unsigned r, at, k, tk;
    int          n, bad;
    bit          ok;
    exp_t        e;
    apply_reset();
    step();
    press_run(r, ok);
    for (int i = 1; i <= 12; i++) begin
      e.at = r + ClkHz * i;
      e.secs = 6'(i);
      sb.push_back(e);
    end
    for (int i = 0; i < 12; i++) begin
      wait_tick(ClkHz + 2, at, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || at !== e.at || r_second !== e.secs) begin
        errors++;
        $display("FAIL clear_pre_tick%0d got cyc=%0d second=%0d want cyc=%0d second=%0d",
                 i + 1, at, r_second, e.at, e.secs);
      end
    end
    btn_run = 1'b1;
    btn_clr = 1'b1;
    k = cyc;
    wait_running(1'b0, Lat + 10, n, ok, tk);
    checks++;
    if (!ok || cyc !== k + Lat + 1 || tk != 0) begin
      errors++;
      $display("FAIL clear_entry got fall at cyc %0d tick=%0d want fall at %0d no tick",
               cyc, tk, k + Lat + 1);
    end
    checks++;
    if (r_second !== 6'd0 || sec !== 1'b0 || sec_tick !== 1'b0) begin
      errors++;
      $display("FAIL clear_state got second=%0d sec=%b tick=%b want 0 0 0",
               r_second, sec, sec_tick);
    end
    bad = 0;
    repeat (30) begin
      step();
      if (sec_tick !== 1'b0 || running !== 1'b0 || r_second !== 6'd0 || sec !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL clear_idle got %0d disturbed cycles want 0", bad);
    end
    btn_run = 1'b0;
    btn_clr = 1'b0;
  endtask

  task automatic test_glitch();
    bit seen = 1'b0;
    apply_reset();
    step();
    btn_run = 1'b1;
    repeat (3) step();
    btn_run = 1'b0;
    repeat (20) begin
      step();
      if (running === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== !DbOn) begin
      errors++;
      $display("FAIL glitch got running_seen=%0b want %0b", seen, !DbOn);
    end
  endtask

  task automatic test_reset_mid();
    int unsigned r, at;
    bit          ok;
    exp_t        e;
    apply_reset();
    step();
    press_run(r, ok);
    wait_tick(ClkHz + 2, at, ok);
    repeat (3) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if ({sec, sec_tick, r_second, running} !== 9'b0) begin
      errors++;
      $display("FAIL reset_mid got sec=%b tick=%b second=%0d running=%b want all 0",
               sec, sec_tick, r_second, running);
    end
    step();
    press_run(r, ok);
    e.at = r + ClkHz;
    e.secs = 6'd1;
    sb.push_back(e);
    wait_tick(ClkHz + 2, at, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || at !== e.at || r_second !== e.secs) begin
      errors++;
      $display("FAIL reset_mid_restart got seen=%0b cyc=%0d second=%0d want cyc=%0d second=%0d",
               ok, at, r_second, e.at, e.secs);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_minute();
    test_pause();
    test_clear();
    test_glitch();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got no finish by cyc %0d want finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
